// File: rtl/esti_ctrl.sv
// esti_ctrl: sample scheduler and bias-calibration controller.
// Latches raw accelerometer words, averages 2^CAL_LOG2 ticks to form a bias,
// then issues one bias-corrected, saturated sample plus a step strobe per
// sample period. est_clear pulses on calibration start and zupt rising edges.
module esti_ctrl #(
  parameter int DIV      = 1000,
  parameter int CAL_LOG2 = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        zupt,
  input  logic        raw_valid,
  input  logic [15:0] raw_acc,
  output logic [15:0] acc_out,
  output logic        step,
  output logic        est_clear,
  output logic        calibrated,
  output logic        busy,
  output logic        overrun,
  output logic [7:0]  missed_cnt
);

  localparam int TW = $clog2(DIV);
  localparam int CW = CAL_LOG2 + 1;
  localparam int SW = 16 + CAL_LOG2;
  localparam logic [TW-1:0] T_LAST = TW'(DIV - 1);
  localparam logic [CW-1:0] C_LAST = CW'((1 << CAL_LOG2) - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CAL  = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [TW-1:0]        timer;
  logic [15:0]          hold;
  logic                 fresh;
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] sum_nxt;
  logic [CW-1:0]        cal_cnt;
  logic [15:0]          bias;
  logic [15:0]          bias_nxt;
  logic                 zupt_d;
  logic                 tick;
  logic                 enter_cal;
  logic                 cal_last;
  logic                 zupt_rise;
  logic [15:0]          sample;
  logic signed [16:0]   diff;
  logic [15:0]          sat;

  // Status outputs are decoded straight from the state register.
  assign calibrated = (state == S_RUN);
  assign busy       = (state != S_IDLE);

  // Tick decode, sample selection and the arithmetic datapath.
  always_comb begin
    tick      = (state != S_IDLE) && !stop && (timer == T_LAST);
    enter_cal = (state == S_IDLE) && start && !stop;
    cal_last  = (cal_cnt == C_LAST);
    zupt_rise = zupt && !zupt_d;
    // A sample arriving in the tick cycle bypasses the hold register.
    sample    = raw_valid ? raw_acc : hold;
    sum_nxt   = sum + $signed({{CAL_LOG2{sample[15]}}, sample});
    // Top 16 bits of the sum are exactly sum >>> CAL_LOG2 (floor average).
    bias_nxt  = sum_nxt[SW-1:CAL_LOG2];
    diff      = $signed({sample[15], sample}) - $signed({bias[15], bias});
    if (diff[16] != diff[15]) begin
      sat = diff[16] ? 16'h8000 : 16'h7FFF;
    end else begin
      sat = diff[15:0];
    end
  end

  // Next-state logic; stop overrides every other transition.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (enter_cal) begin
          state_nxt = S_CAL;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_CAL: begin
        if (stop) begin
          state_nxt = S_IDLE;
        end else if (tick && cal_last) begin
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_CAL;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_RUN;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Sample-period timer: runs only while busy, restarts on stop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if ((state == S_IDLE) || stop || (timer == T_LAST)) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end

  // Hold register, freshness, overrun and missed-sample bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold       <= 16'd0;
      fresh      <= 1'b0;
      overrun    <= 1'b0;
      missed_cnt <= 8'd0;
    end else begin
      if (raw_valid) begin
        hold <= raw_acc;
      end
      if (tick) begin
        fresh <= 1'b0;
      end else if (raw_valid) begin
        fresh <= 1'b1;
      end
      if (enter_cal) begin
        overrun <= 1'b0;
      end else if (raw_valid && fresh && !tick) begin
        overrun <= 1'b1;
      end
      if (enter_cal) begin
        missed_cnt <= 8'd0;
      end else if (tick && !raw_valid && !fresh && (missed_cnt != 8'd255)) begin
        missed_cnt <= missed_cnt + 8'd1;
      end
    end
  end

  // Calibration accumulator and bias latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum     <= '0;
      cal_cnt <= '0;
      bias    <= 16'd0;
    end else if (enter_cal) begin
      sum     <= '0;
      cal_cnt <= '0;
    end else if (tick && (state == S_CAL)) begin
      sum     <= sum_nxt;
      cal_cnt <= cal_cnt + CW'(1);
      if (cal_last) begin
        bias <= bias_nxt;
      end
    end
  end

  // Registered estimator outputs: corrected sample, step and clear strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_out   <= 16'd0;
      step      <= 1'b0;
      est_clear <= 1'b0;
      zupt_d    <= 1'b0;
    end else begin
      zupt_d    <= zupt;
      step      <= tick && (state == S_RUN);
      est_clear <= enter_cal || ((state == S_RUN) && !stop && zupt_rise);
      if (tick && (state == S_RUN)) begin
        acc_out <= sat;
      end
    end
  end

endmodule
